sbox_seq: RTL and testbench

SBOX_SEQ -- requirements
Module: sbox_seq

---
 rtl/sbox_seq_pkg.sv | 62 ++++++
 rtl/sbox_seq_if.sv | 33 +++
 rtl/sbox_seq_table.sv | 61 ++++++
 rtl/sbox_seq.sv | 143 ++++++++++++++
 tb/tb_sbox_seq.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sbox_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sbox_seq_pkg
//  Description : Shared types, widths and helpers for the sequential DES
//                S-box substitution unit.
//                - state_t     : IDLE / LOOKUP / DONE sequencer states
//                - sboxIdx_t   : 3-bit index of the active S-box (S1 = 0)
//                - sliceIn     : pick the 6-bit field of a 48-bit block
//                - insertNibble: replace one 4-bit field of a 32-bit word
//  Revision    : 1.0 - initial release
// ============================================================================
package sbox_seq_pkg;

    localparam int c_SBOX_COUNT  = 8;
    localparam int c_SBOX_IN_W   = 6;
    localparam int c_SBOX_OUT_W  = 4;
    localparam int c_BLOCK_IN_W  = 48;
    localparam int c_BLOCK_OUT_W = 32;

    typedef logic [2:0] sboxIdx_t;

    localparam sboxIdx_t c_LAST_SBOX = sboxIdx_t'(c_SBOX_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        DONE   = 2'd2
    } state_t;

    // S1 uses the most significant 6 bits, S8 the least significant.
    function automatic logic [c_SBOX_IN_W-1:0] sliceIn(
        input logic [c_BLOCK_IN_W-1:0] blk,
        input sboxIdx_t                idx
    );
        logic [c_SBOX_IN_W-1:0] res;
        res = '0;
        for (int i = 0; i < c_SBOX_COUNT; i++) begin
            if (idx == sboxIdx_t'(i)) begin
                res = blk[c_BLOCK_IN_W-1-c_SBOX_IN_W*i -: c_SBOX_IN_W];
            end
        end
        return res;
    endfunction

    // S1 result lands in the most significant nibble, S8 in the least.
    function automatic logic [c_BLOCK_OUT_W-1:0] insertNibble(
        input logic [c_BLOCK_OUT_W-1:0] word,
        input sboxIdx_t                 idx,
        input logic [c_SBOX_OUT_W-1:0]  nib
    );
        logic [c_BLOCK_OUT_W-1:0] res;
        res = word;
        for (int i = 0; i < c_SBOX_COUNT; i++) begin
            if (idx == sboxIdx_t'(i)) begin
                res[c_BLOCK_OUT_W-1-c_SBOX_OUT_W*i -: c_SBOX_OUT_W] = nib;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : sbox_seq_if
//  Description : Valid/ready bus of the sequential S-box unit.
//                InValid/InReady/DataIn  : 48-bit input block handshake
//                OutValid/OutReady/DataOut: 32-bit result handshake
//                Busy                    : unit is not idle
//                master = producer/consumer side, slave = the unit itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sbox_seq_if;
    import sbox_seq_pkg::*;

    logic                     InValid;
    logic                     InReady;
    logic [c_BLOCK_IN_W-1:0]  DataIn;
    logic                     OutValid;
    logic                     OutReady;
    logic [c_BLOCK_OUT_W-1:0] DataOut;
    logic                     Busy;

    modport master (
        output InValid, DataIn, OutReady,
        input  InReady, OutValid, DataOut, Busy
    );

    modport slave (
        input  InValid, DataIn, OutReady,
        output InReady, OutValid, DataOut, Busy
    );

endinterface
`default_nettype wire

// File: rtl/sbox_seq_table.sv
`default_nettype none
// ============================================================================
//  Module      : sbox_table
//  Description : The eight DES S-boxes, purely combinational.
//                SboxSel[2:0] : S-box select (0 = S1 ... 7 = S8)
//                DataIn[5:0]  : raw 6-bit S-box input
//                DataOut[3:0] : 4-bit substitution value
//  Revision    : 1.0 - initial release
// ============================================================================
module sbox_table
    import sbox_seq_pkg::*;
(
    input  wire sboxIdx_t               SboxSel,
    input  wire [c_SBOX_IN_W-1:0]       DataIn,
    output logic [c_SBOX_OUT_W-1:0]     DataOut
);

    // Each constant holds the four 16-entry rows of one S-box, row 0 first,
    // entry 0 in the top nibble.
    localparam logic [255:0] c_S1 = {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
                                     64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D};
    localparam logic [255:0] c_S2 = {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
                                     64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9};
    localparam logic [255:0] c_S3 = {64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1,
                                     64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C};
    localparam logic [255:0] c_S4 = {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
                                     64'hA690CB7DF13E5284, 64'h3F06A1D89450C72E};
    localparam logic [255:0] c_S5 = {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
                                     64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453};
    localparam logic [255:0] c_S6 = {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
                                     64'h9EF528C3704A1DB6, 64'h432C95FABE17608D};
    localparam logic [255:0] c_S7 = {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
                                     64'h14BDC37EAF680592, 64'h6BD814A7950FE23C};
    localparam logic [255:0] c_S8 = {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
                                     64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

    logic [255:0] w_tbl;
    logic [5:0]   w_entry;

    // DES row is the outer bit pair {b5,b0}, column the inner four bits.
    assign w_entry = {DataIn[5], DataIn[0], DataIn[4:1]};

    always_comb begin
        w_tbl = c_S1;
        case (SboxSel)
            3'd0:    w_tbl = c_S1;
            3'd1:    w_tbl = c_S2;
            3'd2:    w_tbl = c_S3;
            3'd3:    w_tbl = c_S4;
            3'd4:    w_tbl = c_S5;
            3'd5:    w_tbl = c_S6;
            3'd6:    w_tbl = c_S7;
            default: w_tbl = c_S8;
        endcase
    end

    // Entry k sits at bit offset 4*(63-k); for a 6-bit k, 63-k is ~k.
    assign DataOut = w_tbl[{~w_entry, 2'b00} +: 4];

endmodule
`default_nettype wire

// File: rtl/sbox_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sbox_seq
//  Description : Sequential DES S-box substitution. A 48-bit block is latched
//                on acceptance and pushed through one shared table unit, one
//                S-box per step (S1..S8), building a 32-bit result.
//                Clk   : rising-edge clock
//                Reset : asynchronous, active-high
//                bus   : sbox_seq_if.slave (in/out handshakes, Busy)
//                REG_LOOKUP = 1 registers the table output (one extra cycle).
//  Revision    : 1.0 - initial release
// ============================================================================
module sbox_seq
    import sbox_seq_pkg::*;
#(
    parameter bit REG_LOOKUP = 1'b0
) (
    input  wire      Clk,
    input  wire      Reset,
    sbox_seq_if.slave bus
);

    state_t                   r_state;
    sboxIdx_t                 r_idx;
    logic [c_BLOCK_IN_W-1:0]  r_inReg;
    logic [c_BLOCK_OUT_W-1:0] r_dataOut;
    logic                     r_inReady;
    logic                     r_outValid;
    logic                     r_busy;

    logic [c_SBOX_IN_W-1:0]   w_tableIn;
    logic [c_SBOX_OUT_W-1:0]  w_tableOut;
    logic                     w_accept;
    logic                     w_outHandshake;

    // Write side of a step: which nibble completes this cycle and its value.
    logic                     w_writeEn;
    sboxIdx_t                 w_writeIdx;
    logic [c_SBOX_OUT_W-1:0]  w_writeNib;

    assign w_accept       = bus.InValid & r_inReady;
    assign w_outHandshake = r_outValid & bus.OutReady;
    assign w_tableIn      = sliceIn(r_inReg, r_idx);

    sbox_table u_table (
        .SboxSel (r_idx),
        .DataIn  (w_tableIn),
        .DataOut (w_tableOut)
    );

    generate
        if (REG_LOOKUP) begin : g_regLookup
            logic [c_SBOX_OUT_W-1:0] r_tablePipe;
            logic                    r_pipeValid;
            sboxIdx_t                r_wrIdx;

            // Address at step i, capture at step i+1: the write index trails
            // the address index by one cycle.
            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    r_tablePipe <= '0;
                    r_pipeValid <= 1'b0;
                    r_wrIdx     <= '0;
                end else if (w_accept) begin
                    r_pipeValid <= 1'b0;
                    r_wrIdx     <= '0;
                end else if (r_state == LOOKUP) begin
                    r_tablePipe <= w_tableOut;
                    r_pipeValid <= 1'b1;
                    if (r_pipeValid && (r_wrIdx != c_LAST_SBOX)) begin
                        r_wrIdx <= r_wrIdx + 3'd1;
                    end
                end
            end

            assign w_writeEn  = (r_state == LOOKUP) & r_pipeValid;
            assign w_writeIdx = r_wrIdx;
            assign w_writeNib = r_tablePipe;
        end else begin : g_combLookup
            assign w_writeEn  = (r_state == LOOKUP);
            assign w_writeIdx = r_idx;
            assign w_writeNib = w_tableOut;
        end
    endgenerate

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_inReg    <= '0;
            r_dataOut  <= '0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_inReg   <= bus.DataIn;
                        r_idx     <= '0;
                        r_state   <= LOOKUP;
                        r_inReady <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                LOOKUP: begin
                    // Address index parks on S8 so it never wraps within a block.
                    if (r_idx != c_LAST_SBOX) begin
                        r_idx <= r_idx + 3'd1;
                    end
                    if (w_writeEn) begin
                        r_dataOut <= insertNibble(r_dataOut, w_writeIdx, w_writeNib);
                        if (w_writeIdx == c_LAST_SBOX) begin
                            r_state    <= DONE;
                            r_outValid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (w_outHandshake) begin
                        r_state    <= IDLE;
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_outValid <= 1'b0;
                    r_inReady  <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.InReady  = r_inReady;
    assign bus.OutValid = r_outValid;
    assign bus.DataOut  = r_dataOut;
    assign bus.Busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sbox_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sbox_seq
//  Description : Scoreboard bench for sbox_seq. Two instances (REG_LOOKUP 0
//                and 1) are exercised one at a time through a select; an
//                input monitor pushes the reference result of every accepted
//                block, an output monitor pops and compares on each output
//                handshake and checks latency and hold behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sbox_seq;
    import sbox_seq_pkg::*;

    // DES S-boxes as rows of 16 entries (entry 0 in the top nibble).
    localparam logic [63:0] ROW_TBL [8][4] = '{
        '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        '{64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D89450C72E},
        '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
    };

    localparam logic [47:0] ALL_ONES = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic [47:0] dataIn;
    logic        outReady;
    int          sel;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sbox_seq_if if0 ();
    sbox_seq_if if1 ();

    assign if0.InValid  = inValid && (sel == 0);
    assign if1.InValid  = inValid && (sel == 1);
    assign if0.DataIn   = dataIn;
    assign if1.DataIn   = dataIn;
    assign if0.OutReady = outReady;
    assign if1.OutReady = outReady;

    sbox_seq #(.REG_LOOKUP(1'b0)) dut0 (.Clk(clk), .Reset(rst), .bus(if0.slave));
    sbox_seq #(.REG_LOOKUP(1'b1)) dut1 (.Clk(clk), .Reset(rst), .bus(if1.slave));

    logic        mInReady, mOutValid, mBusy;
    logic [31:0] mDataOut;
    assign mInReady  = (sel == 1) ? if1.InReady  : if0.InReady;
    assign mOutValid = (sel == 1) ? if1.OutValid : if0.OutValid;
    assign mBusy     = (sel == 1) ? if1.Busy     : if0.Busy;
    assign mDataOut  = (sel == 1) ? if1.DataOut  : if0.DataOut;

    int passCnt  = 0;
    int checkCnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", name, act, exp, $time, sel);
    endtask

    // Reference: each 6-bit field selects row {b5,b0}, column b4..b1.
    function automatic logic [31:0] refModel(input logic [47:0] d);
        logic [31:0] r;
        logic [5:0]  six;
        logic [63:0] rowBits;
        int          row, col;
        r = '0;
        for (int s = 0; s < 8; s++) begin
            six     = d[47 - 6*s -: 6];
            row     = int'({six[5], six[0]});
            col     = int'(six[4:1]);
            rowBits = ROW_TBL[s][row];
            r[31 - 4*s -: 4] = rowBits[63 - 4*col -: 4];
        end
        return r;
    endfunction

    typedef struct {
        logic [31:0] data;
        int          acceptCyc;
    } expEntry_t;

    expEntry_t   expQ[$];
    expEntry_t   popped;
    int          acceptCount = 0;
    int          lastAccept  = 0;
    int          prevAccept  = 0;
    logic [31:0] lastOut     = '0;

    // Input monitor: an accepting edge follows any negedge with InValid&InReady.
    always @(negedge clk) begin
        if (!rst && (sel == 0 ? if0.InValid : if1.InValid) && mInReady) begin
            expQ.push_back('{refModel(dataIn), cyc + 1});
            prevAccept = lastAccept;
            lastAccept = cyc + 1;
            acceptCount++;
        end
    end

    // Output monitor.
    logic        prevOV = 1'b0;
    logic        prevHS = 1'b0;
    logic [31:0] prevDO = '0;
    always @(negedge clk) begin
        if (rst) begin
            prevOV = 1'b0;
            prevHS = 1'b0;
        end else begin
            if (mOutValid && !prevOV) begin
                chk("output expected", 64'(expQ.size() != 0), 1);
                if (expQ.size() != 0)
                    chk("latency", 64'(cyc - expQ[0].acceptCyc), (sel == 1) ? 9 : 8);
            end
            if (prevOV && !prevHS) begin
                chk("OutValid hold", 64'(mOutValid), 1);
                chk("DataOut hold", 64'(mDataOut), 64'(prevDO));
            end
            if (mOutValid && outReady && expQ.size() != 0) begin
                popped  = expQ.pop_front();
                lastOut = mDataOut;
                chk("DataOut", 64'(mDataOut), 64'(popped.data));
            end
            prevOV = mOutValid;
            prevDO = mDataOut;
            prevHS = mOutValid && outReady;
        end
    end

    task automatic sendBlock(input logic [47:0] d);
        int n0;
        n0 = acceptCount;
        @(posedge clk); #1;
        dataIn  = d;
        inValid = 1'b1;
        for (int g = 0; g < 100 && acceptCount == n0; g++) @(posedge clk);
        #1;
        inValid = 1'b0;
        chk("accepted", 64'(acceptCount - n0), 1);
    endtask

    task automatic waitIdle();
        for (int g = 0; g < 300 && (expQ.size() != 0 || mBusy); g++) @(negedge clk);
        @(negedge clk);
        chk("drain queue", 64'(expQ.size()), 0);
        chk("drain busy", 64'(mBusy), 0);
    endtask

    task automatic backToBack(input int s);
        int n0;
        sel      = s;
        outReady = 1'b1;
        n0       = acceptCount;
        @(posedge clk); #1;
        dataIn  = {16'($urandom), $urandom};
        inValid = 1'b1;
        for (int g = 0; g < 50 && acceptCount == n0; g++) @(posedge clk);
        #1;
        dataIn = {16'($urandom), $urandom};
        for (int g = 0; g < 50 && acceptCount < n0 + 2; g++) @(posedge clk);
        #1;
        inValid = 1'b0;
        chk("b2b accepts", 64'(acceptCount - n0), 2);
        chk("b2b spacing", 64'(lastAccept - prevAccept), (s == 1) ? 11 : 10);
        waitIdle();
    endtask

    task automatic randomRun(input int s);
        sel = s;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            inValid  = ($urandom_range(0, 2) == 0);
            dataIn   = {16'($urandom), $urandom};
            outReady = ($urandom_range(0, 3) != 0);
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        waitIdle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        inValid  = 1'b0;
        dataIn   = '0;
        outReady = 1'b0;
        sel      = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst InReady0",  64'(if0.InReady),  1);
        chk("rst OutValid0", 64'(if0.OutValid), 0);
        chk("rst Busy0",     64'(if0.Busy),     0);
        chk("rst DataOut0",  64'(if0.DataOut),  0);
        chk("rst InReady1",  64'(if1.InReady),  1);
        chk("rst OutValid1", 64'(if1.OutValid), 0);
        chk("rst Busy1",     64'(if1.Busy),     0);
        chk("rst DataOut1",  64'(if1.DataOut),  0);

        // All-zero block, combinational table.
        sel = 0; outReady = 1'b1;
        sendBlock('0);
        waitIdle();
        chk("zero vector", 64'(lastOut), 64'h0000_0000_EFA7_2C4D);

        // All-ones block, registered table.
        sel = 1;
        sendBlock(ALL_ONES);
        waitIdle();
        chk("ones vector", 64'(lastOut), 64'h0000_0000_D9CE_3DCB);

        // Output stalled for 20 cycles; an InValid pulse meanwhile is ignored.
        sel = 0; outReady = 1'b0;
        sendBlock('0);
        for (int g = 0; g < 30 && !mOutValid; g++) @(negedge clk);
        chk("stall OutValid", 64'(mOutValid), 1);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            inValid = (c == 5 || c == 6);
            dataIn  = ALL_ONES;
            @(negedge clk);
            chk("stall InReady", 64'(mInReady), 0);
            chk("stall DataOut", 64'(mDataOut), 64'h0000_0000_EFA7_2C4D);
        end
        @(posedge clk); #1;
        inValid  = 1'b0;
        outReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release InReady",  64'(mInReady),  1);
        chk("release OutValid", 64'(mOutValid), 0);
        chk("release Busy",     64'(mBusy),     0);
        waitIdle();

        // Input changes right after acceptance.
        sendBlock('0);
        dataIn = ALL_ONES;
        waitIdle();
        chk("latched input", 64'(lastOut), 64'h0000_0000_EFA7_2C4D);

        // Reset during the lookup of step 4 aborts the block.
        sendBlock('0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        expQ.delete();
        #1;
        chk("abort OutValid", 64'(mOutValid), 0);
        chk("abort DataOut",  64'(mDataOut),  0);
        chk("abort Busy",     64'(mBusy),     0);
        @(posedge clk); #1;
        rst = 1'b0;
        sendBlock(ALL_ONES);
        waitIdle();
        chk("post-abort vector", 64'(lastOut), 64'h0000_0000_D9CE_3DCB);

        backToBack(0);
        backToBack(1);

        randomRun(0);
        randomRun(1);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
`default_nettype wire
